hier_resp_collector: RTL and testbench

// Upstream (responder-side) end of the root-to-leaf hierarchy fan-out.

---
 rtl/hier_resp_collector.sv | 141 ++++++++++++++
 tb/tb_hier_resp_collector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hier_resp_collector.sv
// hier_resp_collector: gathers valid/ready response beats from N_CHILD children,
// arbitrates round-robin, buffers them in a show-ahead FIFO and presents each
// beat upstream tagged with the index of the child that produced it.
// Optional feature macro: HIER_COLLECT_PARITY_EN adds a per-entry even-parity
// bit over {source index, payload} and the up_parity output port.
module hier_resp_collector #(
  parameter int N_CHILD    = 5,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CHILD-1:0]            child_valid,
  input  logic [N_CHILD*DATA_W-1:0]     child_data,
  output logic [N_CHILD-1:0]            child_ready,
  output logic                          up_valid,
  input  logic                          up_ready,
  output logic [DATA_W-1:0]             up_data,
  output logic [$clog2(N_CHILD)-1:0]    up_src,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef HIER_COLLECT_PARITY_EN
  ,
  output logic                          up_parity
`endif
);

  localparam int IDX_W = $clog2(N_CHILD);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHILD - 1);

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [IDX_W-1:0]  mem_src  [FIFO_DEPTH];
`ifdef HIER_COLLECT_PARITY_EN
  logic              mem_par  [FIFO_DEPTH];
`endif

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_found;
  logic              can_push;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] grant_data;

  assign up_valid = (fifo_level != '0);
  assign pop      = up_valid && up_ready;
  // Reset gates acceptance so no child sees ready while the collector is held in reset.
  assign can_push = rst_n && ((fifo_level < DEPTH_L) || pop);
  assign push     = can_push && grant_found;

  assign grant_data = child_data[int'(grant_idx)*DATA_W +: DATA_W];

  // Show-ahead head: outputs come straight from the stored entry at the read pointer.
  assign up_data = mem_data[rd_ptr];
  assign up_src  = mem_src[rd_ptr];
`ifdef HIER_COLLECT_PARITY_EN
  assign up_parity = mem_par[rd_ptr];
`endif

  // Round-robin search: first valid child starting at rr_ptr, wrapping mod N_CHILD.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 0; off < N_CHILD; off++) begin
      cand = IDX_W'((int'(rr_ptr) + off) % N_CHILD);
      if (!grant_found && child_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot ready to the granted child, only when the FIFO can take the beat.
  always_comb begin
    child_ready = '0;
    if (push) child_ready[grant_idx] = 1'b1;
  end

  // FIFO storage; entries are cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_src[i]  <= '0;
`ifdef HIER_COLLECT_PARITY_EN
        mem_par[i]  <= 1'b0;
`endif
      end
    end else if (push) begin
      mem_data[wr_ptr] <= grant_data;
      mem_src[wr_ptr]  <= grant_idx;
`ifdef HIER_COLLECT_PARITY_EN
      mem_par[wr_ptr]  <= ^{grant_idx, grant_data};
`endif
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two; level tracks push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Priority pointer moves just past the most recently granted child.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_level == DEPTH_L) |-> (!push || pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_level == '0) |-> !pop);
  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_level <= DEPTH_L);
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(child_ready));
  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (up_valid && !up_ready) |=> ($stable(up_data) && $stable(up_src)));

endmodule

// File: tb/tb_hier_resp_collector.sv
// Scoreboard bench for hier_resp_collector: a reference model process predicts
// grants and queues expected beats; a separate monitor compares DUT outputs.
module tb_hier_resp_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  child_valid = '0;
  logic [39:0] child_data = '0;
  logic [4:0]  child_ready;
  logic        up_valid;
  logic        up_ready = 1'b0;
  logic [7:0]  up_data;
  logic [2:0]  up_src;
  logic [2:0]  fifo_level;
`ifdef HIER_COLLECT_PARITY_EN
  logic        up_parity;
`endif

  always #5 clk = ~clk;

  hier_resp_collector #(.N_CHILD(5), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .child_valid(child_valid),
    .child_data(child_data),
    .child_ready(child_ready),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .up_data(up_data),
    .up_src(up_src),
    .fifo_level(fifo_level)
`ifdef HIER_COLLECT_PARITY_EN
    ,
    .up_parity(up_parity)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_rr = 0;
  int          m_level = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          beats = 0;
  int          t5_start = 0;
  logic [4:0]  exp_ready = '0;
  int          exp_lvl = 0;
  logic        exp_uv = 1'b0;
  int          exp_src [256];
  logic [7:0]  exp_data [256];
  logic        exp_par [256];

  logic [4:0]  acc_last = '0;
  logic        final_chk = 1'b0;

  // Reference model: evaluated once inputs for the cycle are settled.
  always @(posedge clk) begin
    int g;
    int c;
    int pop_m;
    logic [7:0] d;
    #2;
    if (!rst_n) begin
      m_rr = 0;
      m_level = 0;
      exp_ready = '0;
      exp_lvl = 0;
      exp_uv = 1'b0;
    end else begin
      exp_lvl = m_level;
      exp_uv = (m_level != 0);
      pop_m = (m_level != 0 && up_ready) ? 1 : 0;
      g = -1;
      for (int off = 0; off < 5; off++) begin
        c = (m_rr + off) % 5;
        if (g < 0 && child_valid[c]) g = c;
      end
      exp_ready = '0;
      if (g >= 0 && (m_level < 4 || pop_m == 1)) begin
        exp_ready[g] = 1'b1;
        d = child_data[g*8 +: 8];
        exp_src[wr_cnt % 256] = g;
        exp_data[wr_cnt % 256] = d;
        exp_par[wr_cnt % 256] = 1'(($countones(d) + $countones(g)) % 2);
        wr_cnt++;
        beats++;
        m_rr = (g + 1) % 5;
        m_level++;
      end
      m_level = m_level - pop_m;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model and pops the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_up_valid", 64'(up_valid), 64'd0);
      check("rst_fifo_level", 64'(fifo_level), 64'd0);
      check("rst_child_ready", 64'(child_ready), 64'd0);
      rd_cnt = wr_cnt;
      acc_last = '0;
    end else begin
      check("fifo_level", 64'(fifo_level), 64'(exp_lvl));
      check("up_valid", 64'(up_valid), 64'(exp_uv));
      check("child_ready", 64'(child_ready), 64'(exp_ready));
      acc_last = child_valid & child_ready;
      if (up_valid && up_ready) begin
        if (rd_cnt == wr_cnt) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got src %0d data %0h expected no beat at %0t",
                   up_src, up_data, $time);
        end else begin
          check("up_src", 64'(up_src), 64'(exp_src[rd_cnt % 256]));
          check("up_data", 64'(up_data), 64'(exp_data[rd_cnt % 256]));
`ifdef HIER_COLLECT_PARITY_EN
          check("up_parity", 64'(up_parity), 64'(exp_par[rd_cnt % 256]));
`endif
          rd_cnt++;
        end
      end
      if (final_chk) begin
        check("drain_pending", 64'(wr_cnt - rd_cnt), 64'd0);
        check("t5_min_beats", 64'((beats - t5_start) >= 20), 64'd1);
      end
    end
  end

  // Each child holds valid/data until accepted, then may raise a fresh beat.
  task automatic drive_cycle(input logic [4:0] mask, input int pv, input int pr);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (child_valid[i] && acc_last[i]) child_valid[i] = 1'b0;
      if (!child_valid[i] && mask[i] && ($urandom_range(99) < pv)) begin
        child_valid[i] = 1'b1;
        child_data[i*8 +: 8] = 8'($urandom);
      end
    end
    up_ready = ($urandom_range(99) < pr);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    child_valid = '0;
    up_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // single beat from child 2
    @(posedge clk);
    #1;
    child_valid = 5'b00100;
    child_data[23:16] = 8'hA5;
    up_ready = 1'b1;
    repeat (4) drive_cycle(5'h00, 0, 100);

    // fairness with all children valid
    apply_reset();
    @(posedge clk);
    #1;
    child_valid = 5'h1f;
    child_data = 40'({$urandom, $urandom});
    up_ready = 1'b1;
    repeat (6) drive_cycle(5'h1f, 100, 100);

    // fill to full, then concurrent push/pop
    apply_reset();
    repeat (8) drive_cycle(5'b00011, 100, 0);
    repeat (5) drive_cycle(5'b00011, 100, 100);

    // reset while beats are buffered
    apply_reset();
    repeat (3) drive_cycle(5'h1f, 100, 0);
    apply_reset();

    // child 3 sends 0x01 (parity 1 when enabled)
    @(posedge clk);
    #1;
    child_valid = 5'b01000;
    child_data[31:24] = 8'h01;
    up_ready = 1'b1;
    repeat (3) drive_cycle(5'h00, 0, 100);

    // random traffic with back-pressure, then drain
    apply_reset();
    t5_start = beats;
    repeat (300) drive_cycle(5'h1f, 30, 60);
    repeat (20) drive_cycle(5'h00, 0, 100);
    @(posedge clk);
    #1 final_chk = 1'b1;
    @(posedge clk);
    #1 final_chk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
